// File: rtl/simframe_pkg.sv
// Shared constants, state encoding and the credit clamp helper for simframe_rate_limiter.
package simframe_pkg;

    localparam int BEAT_BYTES = 64;
    localparam int CREDIT_W   = 41;
    localparam int CAP_W      = 40;

    localparam logic signed [CREDIT_W-1:0] BEAT_CREDIT = 41'sd64;
    localparam logic signed [CREDIT_W:0]   BEAT_DEBIT  = 42'sd64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_META = 2'd2
    } state_t;

    // Clamp a widened credit sum to the (unsigned) bucket cap.
    function automatic logic signed [CREDIT_W:0] clamp_to_cap(
        input logic signed [CREDIT_W:0] value,
        input logic [CAP_W-1:0]         cap
    );
        logic signed [CREDIT_W:0] cap_ext;
        cap_ext = $signed({2'b00, cap});
        if (value > cap_ext) begin
            clamp_to_cap = cap_ext;
        end else begin
            clamp_to_cap = value;
        end
    endfunction

endpackage

// File: rtl/simframe_rate_limiter_if.sv
// AXI-Stream beat bundle used on both sides of simframe_rate_limiter.
interface simframe_rate_limiter_if #(
    parameter int DW = 512
);
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/simframe_rate_limiter_usec_ticker.sv
// Free-running 0..CLK_MHZ-1 counter; tick is high on the cycle the counter wraps.
module usec_ticker #(
    parameter int CLK_MHZ = 250
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);
    localparam int CNT_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_MHZ - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = (cnt_r == CNT_LAST);

    // Cycle counter, wraps once per microsecond.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/simframe_rate_limiter.sv
// Token-bucket pacer for simframe beats with one registered output beat.
// Define SIMFRAME_METADATA_EN to append the metadata beat after every frame.
module simframe_rate_limiter
    import simframe_pkg::*;
#(
    parameter int DW            = 512,
    parameter int CLK_MHZ       = 250,
    parameter int MAX_CREDIT_US = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [31:0]            bytes_per_usec,
    input  logic [DW-1:0]          metadata,
    simframe_rate_limiter_if.slave  axis_in,
    simframe_rate_limiter_if.master axis_out
);
    state_t                     state_r;
    state_t                     state_s;
    logic [DW-1:0]              data_r;
    logic                       last_r;
    logic                       valid_r;
    logic                       meta_pend_r;
    logic signed [CREDIT_W-1:0] credit_r;
    logic [CAP_W-1:0]           cap_s;
    logic signed [CREDIT_W:0]   refill_s;
    logic signed [CREDIT_W:0]   clamped_s;
    logic signed [CREDIT_W:0]   next_credit_s;
    logic                       tick_s;
    logic                       credit_ok_s;
    logic                       in_ready_s;
    logic                       load_s;
`ifdef SIMFRAME_METADATA_EN
    logic                       load_meta_s;
`else
    logic                       unused_metadata_s;
    assign unused_metadata_s = ^metadata;
`endif

    usec_ticker #(.CLK_MHZ(CLK_MHZ)) u_ticker (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick_s)
    );

    // Clamp runs every cycle, so lowering the rate shrinks the bucket at once.
    assign cap_s         = {8'd0, bytes_per_usec} * CAP_W'(MAX_CREDIT_US);
    assign refill_s      = $signed({credit_r[CREDIT_W-1], credit_r})
                         + (tick_s ? $signed({10'd0, bytes_per_usec}) : 42'sd0);
    assign clamped_s     = clamp_to_cap(refill_s, cap_s);
    assign next_credit_s = clamped_s - (load_s ? BEAT_DEBIT : 42'sd0);
    assign credit_ok_s   = (credit_r >= BEAT_CREDIT);

    // Next-state, input ready and load decisions.
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        load_s     = 1'b0;
`ifdef SIMFRAME_METADATA_EN
        load_meta_s = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                in_ready_s = credit_ok_s;
                if (axis_in.tvalid && credit_ok_s) begin
                    load_s  = 1'b1;
                    state_s = S_SEND;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SEND: begin
                in_ready_s = axis_out.tready & credit_ok_s & ~meta_pend_r;
                if (axis_in.tvalid && in_ready_s) begin
                    load_s  = 1'b1;
                    state_s = S_SEND;
                end else if (axis_out.tready && meta_pend_r) begin
                    state_s = S_META;
                end else if (axis_out.tready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_SEND;
                end
            end
`ifdef SIMFRAME_METADATA_EN
            // Metadata is loaded without a credit check and may drive credit negative.
            S_META: begin
                load_s      = 1'b1;
                load_meta_s = 1'b1;
                state_s     = S_SEND;
            end
`endif
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, output valid and credit registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r  <= S_IDLE;
            valid_r  <= 1'b0;
            credit_r <= {CREDIT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            valid_r  <= (state_s == S_SEND);
            credit_r <= next_credit_s[CREDIT_W-1:0];
        end
    end

    // Held output beat; meta_pend_r remembers that the held beat closed a frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_r      <= {DW{1'b0}};
            last_r      <= 1'b0;
            meta_pend_r <= 1'b0;
`ifdef SIMFRAME_METADATA_EN
        end else if (load_meta_s) begin
            data_r      <= metadata;
            last_r      <= 1'b1;
            meta_pend_r <= 1'b0;
        end else if (load_s) begin
            data_r      <= axis_in.tdata;
            last_r      <= 1'b0;
            meta_pend_r <= axis_in.tlast;
`else
        end else if (load_s) begin
            data_r      <= axis_in.tdata;
            last_r      <= axis_in.tlast;
            meta_pend_r <= 1'b0;
`endif
        end else begin
            data_r      <= data_r;
            last_r      <= last_r;
            meta_pend_r <= meta_pend_r;
        end
    end

    assign axis_in.tready  = in_ready_s;
    assign axis_out.tdata  = data_r;
    assign axis_out.tlast  = last_r;
    assign axis_out.tvalid = valid_r;
endmodule
